// File: rtl/intellight_s00_axi_regs.sv
// intellight_s00_axi_regs: AXI4-Lite slave with four RW config words, status/version RO words.
// Optional sticky status-edge interrupt at 0x18 enabled by INTELLIGHT_REGS_IRQ_EN.
`default_nettype none

module intellight_s00_axi_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] VERSION_ID         = 32'h0001_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     cfg_reg0,
  output logic [31:0]                     cfg_reg1,
  output logic [31:0]                     cfg_reg2,
  output logic [31:0]                     cfg_reg3,
  output logic                            start_pulse,
  input  logic [31:0]                     core_status,
  output logic                            irq
);

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e     wstate_q, wstate_d;
  rstate_e     rstate_q, rstate_d;
  logic        run_q;
  logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [2:0]  awidx_q, awidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] cfg_q [4];
  logic [31:0] cfg_d [4];
  logic        pulse_q, pulse_d;
  logic        irq_clr;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;
  logic [31:0] irq_rd;

  // run_q keeps the READY outputs low while reset is asserted.
  assign S_AXI_AWREADY = run_q && (wstate_q == W_IDLE) && !aw_lat_q;
  assign S_AXI_WREADY  = run_q && (wstate_q == W_IDLE) && !w_lat_q;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = run_q && (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign cfg_reg0      = cfg_q[0];
  assign cfg_reg1      = cfg_q[1];
  assign cfg_reg2      = cfg_q[2];
  assign cfg_reg3      = cfg_q[3];
  assign start_pulse   = pulse_q;

  always_comb begin
    wstate_d = wstate_q;
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cfg_d    = cfg_q;
    pulse_d  = 1'b0;
    irq_clr  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_lat_d = 1'b1;
          awidx_d  = S_AXI_AWADDR[4:2];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_lat_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_lat_d && w_lat_d) begin
          if (!awidx_d[2]) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb_d[b]) cfg_d[awidx_d[1:0]][8*b +: 8] = wdata_d[8*b +: 8];
            end
          end
          pulse_d  = (awidx_d == 3'd0) && wstrb_d[0] && wdata_d[0];
          irq_clr  = (awidx_d == 3'd6) && wdata_d[0];
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rd_word = cfg_q[0];
      3'd1:    rd_word = cfg_q[1];
      3'd2:    rd_word = cfg_q[2];
      3'd3:    rd_word = cfg_q[3];
      3'd4:    rd_word = core_status;
      3'd5:    rd_word = VERSION_ID;
      3'd6:    rd_word = irq_rd;
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        rdata_d  = rd_word;
        rstate_d = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      run_q    <= 1'b0;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
      pulse_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      run_q    <= 1'b1;
      aw_lat_q <= aw_lat_d;
      w_lat_q  <= w_lat_d;
      awidx_q  <= awidx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cfg_q    <= cfg_d;
      pulse_q  <= pulse_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef INTELLIGHT_REGS_IRQ_EN
  logic stat_prev_q, irq_q, irq_d, stat_edge;

  // A rising edge in the same cycle as a clear keeps the interrupt pending.
  assign stat_edge = core_status[0] && !stat_prev_q;
  assign irq_d     = irq_clr ? stat_edge : (irq_q || stat_edge);
  assign irq       = irq_q;
  assign irq_rd    = {31'b0, irq_q};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      stat_prev_q <= core_status[0];
      irq_q       <= irq_d;
    end
  end
`else
  assign irq    = 1'b0;
  assign irq_rd = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], irq_clr};

endmodule

`default_nettype wire
